// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// Inputs above the largest displayable value are clamped to all nines and
// flagged with ovf. Results are held between conversions; a busy/done
// handshake gives a fixed latency of WIDTH cycles per conversion.
module bcd_seq_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SAT   = 10**DIGITS - 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    bin_sr;
    logic [BCD_W-1:0]    bcd_sr;
    logic [CNT_W-1:0]    cnt;
    logic                ovf_pend;

    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_nxt;
    logic [WIDTH-1:0]    bin_nxt;

    // True when the value cannot be shown in DIGITS decimal digits.
    function automatic logic is_over(input logic [WIDTH-1:0] v);
        return (64'(v) > 64'(SAT));
    endfunction

    // Clamp to the display limit; clamping also guarantees the top digit
    // never carries out during the add-3 steps.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] v);
        return is_over(v) ? WIDTH'(SAT) : v;
    endfunction

    // Add 3 to every nibble that is 5 or more, so the following shift
    // produces a correct decimal carry into the next digit.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // One double-dabble iteration: adjust digits, then shift the combined register left.
    always_comb begin
        bcd_adj = add3(bcd_sr);
        {bcd_nxt, bin_nxt} = {bcd_adj, bin_sr} << 1;
    end

    // Control FSM, scratch datapath and registered result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr   <= saturate(bin);
                        ovf_pend <= is_over(bin);
                        bcd_sr   <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_sr <= bcd_nxt;
                    bin_sr <= bin_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        bcd   <= bcd_nxt;
                        ovf   <= ovf_pend;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter: stimulus pushes reference results
// computed with decimal arithmetic; a monitor pops them on every done pulse
// and checks held outputs, busy duration and reset behaviour in between.
module tb_bcd_seq_converter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    bcd_seq_converter #(.WIDTH(16), .DIGITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: clamp to 9999, then split into decimal digits.
    function automatic exp_t ref_conv(input logic [15:0] v);
        exp_t r;
        int   n;
        n     = int'(v);
        r.ovf = (n > 9999);
        if (n > 9999) n = 9999;
        r.bcd = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
        return r;
    endfunction

    task automatic push_exp(input logic [15:0] v);
        sb.push_back(ref_conv(v));
    endtask

    // One full conversion; bin is scrambled while busy to show it is not resampled.
    task automatic run(input logic [15:0] v);
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        push_exp(v);
        @(negedge clk);
        start = 1'b0;
        repeat (16) begin
            @(negedge clk);
            bin = 16'($urandom);
        end
    endtask

    // Monitor: compares on done, checks held values and busy length otherwise.
    initial begin : monitor
        logic [15:0] held_bcd;
        logic        held_ovf;
        logic        prev_done;
        int          busy_cnt;
        exp_t        e;
        held_bcd  = '0;
        held_ovf  = 1'b0;
        prev_done = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("reset_busy", 32'(busy), 32'd0);
                chk("reset_done", 32'(done), 32'd0);
                chk("reset_bcd",  32'(bcd),  32'd0);
                chk("reset_ovf",  32'(ovf),  32'd0);
                sb.delete();
                held_bcd  = '0;
                held_ovf  = 1'b0;
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                chk("busy_and_done", 32'(busy & done), 32'd0);
                if (done) begin
                    chk("done_one_cycle", 32'(prev_done), 32'd0);
                    if (sb.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_done: got done=1 expected no pending conversion at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        chk("result_bcd", 32'(bcd), 32'(e.bcd));
                        chk("result_ovf", 32'(ovf), 32'(e.ovf));
                        held_bcd = e.bcd;
                        held_ovf = e.ovf;
                    end
                    chk("busy_cycles", 32'(busy_cnt), 32'd16);
                    busy_cnt = 0;
                end else begin
                    chk("held_bcd", 32'(bcd), 32'(held_bcd));
                    chk("held_ovf", 32'(ovf), 32'(held_ovf));
                    if (busy) busy_cnt++;
                end
                prev_done = done;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_bcd",  32'(bcd),  32'd0);
        chk("idle_ovf",  32'(ovf),  32'd0);

        // Basic value and boundaries.
        run(16'd1234);
        run(16'd9999);
        run(16'd10000);
        run(16'd65535);
        run(16'd0);

        // Start during busy must be ignored.
        @(negedge clk);
        bin   = 16'd42;
        start = 1'b1;
        push_exp(16'd42);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        bin   = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        run(16'd8765);

        // Back-to-back conversions with start held high.
        @(negedge clk);
        bin   = 16'd5;
        start = 1'b1;
        push_exp(16'd5);
        push_exp(16'd6);
        push_exp(16'd7);
        repeat (17) @(negedge clk);
        bin = 16'd6;
        repeat (17) @(negedge clk);
        bin = 16'd7;
        repeat (17) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a conversion aborts without done.
        @(negedge clk);
        bin   = 16'd4321;
        start = 1'b1;
        push_exp(16'd4321);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bcd",  32'(bcd),  32'd0);
        run(16'd4321);

        // Randomized values, half within range and half across the full input space.
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) run(16'($urandom_range(0, 9999)));
            else            run(16'($urandom));
        end

        repeat (4) @(negedge clk);
        chk("all_results_seen", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
